sap1_datapath: RTL and testbench
================================

# sap1_datapath

Register-transfer datapath of the SAP-1 computer, the direct consumer of the controller/sequencer's 12-bit control word. Holds the program counter, MAR, 16×8 program/data RAM, instruction register, accumulator A, register B, adder/subtracter and output register around a single 8-bit W bus. Returns the IR opcode nibble to the sequencer. Provides a program-load port that fills RAM before a run.

## Interface
Parameters:
- none.

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `CLR` in 1: reset, synchronous, active-high.
- `Cp` in 1: increment PC.
- `Ep` in 1: drive PC onto W bus.
- `Lm_bar` in 1: load MAR from W[3:0] (active low).
- `CE_bar` in 1: drive RAM[MAR] onto W bus (active low).
- `Li_bar` in 1: load IR from W (active low).
- `Ei_bar` in 1: drive IR[3:0] onto W bus (active low).
- `La_bar` in 1: load A from W (active low).
- `Ea` in 1: drive A onto W bus.
- `Su` in 1: ALU mode; 0 = add, 1 = subtract.
- `Eu` in 1: drive ALU result onto W bus.
- `Lb_bar` in 1: load B from W (active low).
- `Lo_bar` in 1: load OUT from W (active low).
- `prog_mode` in 1: 1 = program-load mode.
- `prog_addr` in 4: RAM address for loading.
- `prog_data` in 8: RAM write data.
- `prog_we` in 1: RAM write strobe in program mode.
- `inst` out 4: IR[7:4], to the sequencer.
- `out_reg` out 8: output register, to the display.
- `pc` out 4: program counter, for debug LEDs.
- `w_bus` out 8: current W bus value.
- `bus_conflict` out 1: sticky multiple-driver error flag.

## Operation
- W bus is combinational: the OR of all enabled sources.
  - Sources: `{4'h0,PC}` when `Ep`; `RAM[MAR]` when `!CE_bar`; `{4'h0,IR[3:0]}` when `!Ei_bar`; `A` when `Ea`; `ALU` when `Eu`.
  - No source enabled gives 8'h00.
- ALU is combinational: `Su ? A−B : A+B`, taken mod 256. There is no carry or flag output.
- Register loads on the rising edge when the load signal is active:
  - MAR ← W[3:0]
  - IR ← W
  - A ← W
  - B ← W
  - OUT ← W
  - PC ← PC+1 (mod 16) when `Cp`.
- Several loads may be active in one cycle. All of them capture the same pre-edge W value. A is the operand for its own ALU result, e.g. `Eu`+`!La_bar` gives A ← A±B.
- Conflict detection:
  - More than one bus source enabled makes the combinational conflict term true.
  - `bus_conflict` is set at the next edge and stays set until `CLR`.
  - The bus still shows the OR of the sources; the datapath does not block loads.
- Program mode (`prog_mode`=1):
  - All control-word inputs are ignored. No register loads, no PC increment, no conflict detection.
  - `prog_we`=1 writes RAM[prog_addr] ← prog_data at the edge.
  - W bus shows RAM[prog_addr] for readback.
- RAM is written only through the program port. No control signal writes RAM.
- `CLR`=1 at an edge:
  - PC, MAR, IR, A, B, OUT and `bus_conflict` go to 0.
  - `CLR` takes priority over every load and over `Cp`.
  - RAM is NOT cleared.
  - A program write with `prog_mode`=1 during `CLR` still completes.

## Timing
- Reset values: `inst`=0, `out_reg`=0, `pc`=0, `bus_conflict`=0. `w_bus`=0 when no source is enabled.
- Register loads: 1-cycle latency. The value is visible on outputs right after the edge.
- RAM read is asynchronous. `RAM[MAR]` is valid in the same cycle MAR changes.
- RAM write: data is readable in the cycle after the `prog_we` edge.
- PC wraps 4'hF → 4'h0.
- Mode switch takes effect at the first edge where `prog_mode` is sampled.

## Test plan
- Load, then run a full program by driving the sequencer's T1–T6 control words:
  - Load RAM: 0:0x09 (LDA 9), 1:0x1A (ADD A), 2:0x2B (SUB B), 3:0xE0 (OUT), 4:0xF0 (HLT), 9:0x10, A:0x14, B:0x18.
  - Required: `out_reg`=0x0C after the OUT T4 edge, `inst`=0xF after the 5th fetch, `pc`=5, `bus_conflict`=0.
- Wrap-around:
  - A=0xF0, B=0x20, `Eu`=1, `La_bar`=0 → A=0x10.
  - Same with `Su`=1, A=0x10, B=0x20 → A=0xF0.
  - 17 `Cp` pulses from PC=0 → `pc`=1.
- Conflict: `Ep`=1 and `Ea`=1 for one cycle → `bus_conflict`=1 from the next edge and it stays 1 with the bus idle; `CLR` pulse → 0.
- Reset mid-program: assert `CLR` during an ADD T5 with `Lb_bar`=0 → PC, MAR, IR, A, B, OUT all 0 and B not loaded; RAM[9] still reads 0x10.
- Program mode isolation: `prog_mode`=1 with `La_bar`=0, `Cp`=1, `Ep`=1 and `Ea`=1 → A, PC and `bus_conflict` unchanged; write 0x5A to addr 7 → `w_bus`=0x5A with `prog_addr`=7.
- Simultaneous loads: W=0x33 from RAM with `Li_bar`, `La_bar`, `Lb_bar` and `Lo_bar` all low → IR, A, B and OUT all read 0x33.

Source files
------------

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B, ALU and OUT around one 8-bit W bus.
// Latency: W bus, ALU and RAM read are combinational; register loads and RAM writes land on the next edge.
// Backpressure: none; the control word is obeyed every cycle, and program mode freezes all registers.
module sap1_datapath (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       Cp,
  input  logic       Ep,
  input  logic       Lm_bar,
  input  logic       CE_bar,
  input  logic       Li_bar,
  input  logic       Ei_bar,
  input  logic       La_bar,
  input  logic       Ea,
  input  logic       Su,
  input  logic       Eu,
  input  logic       Lb_bar,
  input  logic       Lo_bar,
  input  logic       prog_mode,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       prog_we,
  output logic [3:0] inst,
  output logic [7:0] out_reg,
  output logic [3:0] pc,
  output logic [7:0] w_bus,
  output logic       bus_conflict
);

  logic [3:0] pc_q, pc_d;
  logic [3:0] mar_q, mar_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] out_q, out_d;
  logic       conflict_q, conflict_d;
  logic [7:0] ram_q [16];

  logic [7:0] alu;
  logic [7:0] bus;
  logic [2:0] n_src;
  logic       conflict_now;

  // ALU: add or subtract, wrapping mod 256, no flags.
  always_comb begin
    alu = Su ? (a_q - b_q) : (a_q + b_q);
  end

  // W bus: wired-OR of enabled sources; in program mode it shows the RAM word being loaded.
  always_comb begin
    bus          = 8'h00;
    n_src        = 3'd0;
    conflict_now = 1'b0;
    if (prog_mode) begin
      bus = ram_q[prog_addr];
    end else begin
      if (Ep)      bus = bus | {4'h0, pc_q};
      if (!CE_bar) bus = bus | ram_q[mar_q];
      if (!Ei_bar) bus = bus | {4'h0, ir_q[3:0]};
      if (Ea)      bus = bus | a_q;
      if (Eu)      bus = bus | alu;
      n_src = {2'b00, Ep} + {2'b00, !CE_bar} + {2'b00, !Ei_bar}
            + {2'b00, Ea} + {2'b00, Eu};
      conflict_now = (n_src > 3'd1);
    end
  end

  // Next-state: every load captures the same pre-edge bus value; program mode holds everything.
  always_comb begin
    pc_d       = pc_q;
    mar_d      = mar_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    out_d      = out_q;
    conflict_d = conflict_q | conflict_now;
    if (!prog_mode) begin
      if (Cp)      pc_d  = pc_q + 4'd1;
      if (!Lm_bar) mar_d = bus[3:0];
      if (!Li_bar) ir_d  = bus;
      if (!La_bar) a_d   = bus;
      if (!Lb_bar) b_d   = bus;
      if (!Lo_bar) out_d = bus;
    end
  end

  // Register file with synchronous clear taking priority over all loads.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      pc_q       <= 4'h0;
      mar_q      <= 4'h0;
      ir_q       <= 8'h00;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      out_q      <= 8'h00;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_q      <= out_d;
      conflict_q <= conflict_d;
    end
  end

  // RAM: written only from the program port, and deliberately unaffected by CLR.
  always_ff @(posedge CLK) begin
    if (prog_mode && prog_we) ram_q[prog_addr] <= prog_data;
  end

  assign inst         = ir_q[7:4];
  assign out_reg      = out_q;
  assign pc           = pc_q;
  assign w_bus        = bus;
  assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Bench for sap1_datapath: directed program run and corner cases, then random control words.
// Expected values come from an abstract model of registers, RAM and bus kept here.
// Inputs change on the falling edge; outputs are sampled 1 time unit after each edge.
module tb_sap1_datapath;

  localparam logic [11:0] IDLE = 12'h3E3;

  logic       CLK = 1'b0;
  logic       CLR, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar;
  logic       prog_mode, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] inst, pc;
  logic [7:0] out_reg, w_bus;
  logic       bus_conflict;

  sap1_datapath dut (
    .CLK(CLK), .CLR(CLR), .Cp(Cp), .Ep(Ep), .Lm_bar(Lm_bar), .CE_bar(CE_bar),
    .Li_bar(Li_bar), .Ei_bar(Ei_bar), .La_bar(La_bar), .Ea(Ea), .Su(Su), .Eu(Eu),
    .Lb_bar(Lb_bar), .Lo_bar(Lo_bar), .prog_mode(prog_mode), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_we(prog_we), .inst(inst), .out_reg(out_reg),
    .pc(pc), .w_bus(w_bus), .bus_conflict(bus_conflict)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_a, m_b, m_out;
  logic       m_conf;
  logic [7:0] m_ram [16];
  logic [7:0] last_bus;
  bit         skip_bus;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: apply inputs, check bus against the model, clock, update model, check outputs.
  task automatic step(input logic [11:0] cw, input logic pm, input logic [3:0] pa,
                      input logic [7:0] pd, input logic pwe, input logic clr);
    logic [7:0] eb;
    logic [7:0] alu;
    int ns;
    @(negedge CLK);
    {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar} = cw;
    prog_mode = pm; prog_addr = pa; prog_data = pd; prog_we = pwe; CLR = clr;
    ns = 0;
    eb = 8'h00;
    alu = Su ? m_a - m_b : m_a + m_b;
    if (pm) eb = m_ram[pa];
    else begin
      if (Ep)      begin eb = eb | {4'h0, m_pc};      ns++; end
      if (!CE_bar) begin eb = eb | m_ram[m_mar];      ns++; end
      if (!Ei_bar) begin eb = eb | {4'h0, m_ir[3:0]}; ns++; end
      if (Ea)      begin eb = eb | m_a;               ns++; end
      if (Eu)      begin eb = eb | alu;               ns++; end
    end
    #1;
    last_bus = w_bus;
    if (!skip_bus) chk("w_bus", w_bus, eb);
    @(posedge CLK);
    if (pm && pwe) m_ram[pa] = pd;
    if (clr) begin
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0; m_conf = 0;
    end else if (!pm) begin
      if (!Lm_bar) m_mar = eb[3:0];
      if (!Li_bar) m_ir  = eb;
      if (!La_bar) m_a   = eb;
      if (!Lb_bar) m_b   = eb;
      if (!Lo_bar) m_out = eb;
      if (Cp)      m_pc  = m_pc + 4'd1;
      if (ns > 1)  m_conf = 1'b1;
    end
    #1;
    chk("pc", {4'h0, pc}, {4'h0, m_pc});
    chk("inst", {4'h0, inst}, {4'h0, m_ir[7:4]});
    chk("out_reg", out_reg, m_out);
    chk("bus_conflict", {7'h0, bus_conflict}, {7'h0, m_conf});
  endtask

  task automatic cw_step(input logic [11:0] cw);
    step(cw, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    step(IDLE, 1'b1, a, d, 1'b1, 1'b0);
  endtask

  // Point MAR at addr by staging addr in RAM, moving it through IR and out of IR[3:0].
  task automatic set_mar(input logic [3:0] addr);
    prog_write(m_mar, {4'h0, addr});
    cw_step(12'h263);
    cw_step(12'h1A3);
  endtask

  task automatic load_via_ram(input logic [3:0] addr, input logic [7:0] val, input logic [11:0] cw);
    set_mar(addr);
    prog_write(addr, val);
    cw_step(cw);
  endtask

  task automatic load_program();
    logic [7:0] img [16];
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'h2B; img[3] = 8'hE0; img[4] = 8'hF0;
    img[9] = 8'h10; img[10] = 8'h14; img[11] = 8'h18;
    for (int i = 0; i < 16; i++) prog_write(4'(i), img[i]);
    step(IDLE, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic fetch();
    cw_step(12'h5E3);
    cw_step(12'hBE3);
    cw_step(12'h263);
  endtask

  task automatic execute();
    case (m_ir[7:4])
      4'h0:    begin cw_step(12'h1A3); cw_step(12'h2C3); cw_step(IDLE); end
      4'h1:    begin cw_step(12'h1A3); cw_step(12'h2E1); cw_step(12'h3C7); end
      4'h2:    begin cw_step(12'h1A3); cw_step(12'h2E1); cw_step(12'h3CF); end
      4'hE:    begin cw_step(12'h3F2); cw_step(IDLE); cw_step(IDLE); end
      default: begin cw_step(IDLE); cw_step(IDLE); cw_step(IDLE); end
    endcase
  endtask

  initial begin
    logic [3:0] pc_save;
    logic [7:0] a_save;
    {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar} = IDLE;
    CLR = 1'b1; prog_mode = 1'b1; prog_addr = 4'h0; prog_data = 8'h00; prog_we = 1'b0;
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;

    // Reset while clearing RAM through the program port (writes must complete under CLR)
    skip_bus = 1'b1;
    for (int i = 0; i < 16; i++) step(IDLE, 1'b1, 4'(i), 8'h00, 1'b1, 1'b1);
    skip_bus = 1'b0;
    chk("reset_pc", {4'h0, pc}, 8'h00);
    chk("reset_out", out_reg, 8'h00);
    chk("reset_inst", {4'h0, inst}, 8'h00);
    chk("reset_conflict", {7'h0, bus_conflict}, 8'h00);
    cw_step(IDLE);
    chk("idle_bus", last_bus, 8'h00);

    // Full program: LDA 9, ADD A, SUB B, OUT, HLT
    load_program();
    for (int n = 0; n < 5; n++) begin
      fetch();
      if (n == 4) chk("run_inst_hlt", {4'h0, inst}, 8'h0F);
      execute();
    end
    chk("run_out", out_reg, 8'h0C);
    chk("run_pc", {4'h0, pc}, 8'h05);
    chk("run_conflict", {7'h0, bus_conflict}, 8'h00);

    // Reset during ADD T5 with Lb_bar low
    step(IDLE, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    fetch(); execute();
    fetch(); cw_step(12'h1A3);
    step(12'h2E1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    chk("rst_mid_pc", {4'h0, pc}, 8'h00);
    chk("rst_mid_inst", {4'h0, inst}, 8'h00);
    chk("rst_mid_out", out_reg, 8'h00);
    cw_step(12'h3F3); chk("rst_mid_a", last_bus, 8'h00);
    cw_step(12'h3E7); chk("rst_mid_b", last_bus, 8'h00);
    cw_step(12'h2E3); chk("rst_mid_mar", last_bus, 8'h09);
    cw_step(12'h3A3); chk("rst_mid_ir_lo", last_bus, 8'h00);
    step(IDLE, 1'b1, 4'h9, 8'h00, 1'b0, 1'b0); chk("rst_mid_ram9", last_bus, 8'h10);

    // Adder/subtracter wrap-around
    load_via_ram(4'hC, 8'hF0, 12'h2C3);
    load_via_ram(4'hD, 8'h20, 12'h2E1);
    cw_step(12'h3C7);
    cw_step(12'h3F3); chk("wrap_add", last_bus, 8'h10);
    cw_step(12'h3CF);
    cw_step(12'h3F3); chk("wrap_sub", last_bus, 8'hF0);

    // PC wrap: 17 increments from 0
    step(IDLE, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cw_step(12'hBE3);
    chk("pc_wrap", {4'h0, pc}, 8'h01);

    // Conflict: sticky until CLR
    cw_step(12'h7F3);
    chk("conflict_set", {7'h0, bus_conflict}, 8'h01);
    for (int i = 0; i < 3; i++) cw_step(IDLE);
    chk("conflict_hold", {7'h0, bus_conflict}, 8'h01);
    chk("conflict_idle_bus", last_bus, 8'h00);
    step(IDLE, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    chk("conflict_clr", {7'h0, bus_conflict}, 8'h00);

    // Program mode ignores the control word
    load_via_ram(4'h3, 8'hA5, 12'h2C3);
    pc_save = m_pc;
    a_save  = m_a;
    step(12'hFD3, 1'b1, 4'h7, 8'h5A, 1'b1, 1'b0);
    step(12'hFD3, 1'b1, 4'h7, 8'h00, 1'b0, 1'b0);
    chk("prog_readback", last_bus, 8'h5A);
    chk("prog_pc_hold", {4'h0, pc}, {4'h0, pc_save});
    chk("prog_conflict_hold", {7'h0, bus_conflict}, 8'h00);
    cw_step(12'h3F3); chk("prog_a_hold", last_bus, a_save);

    // Simultaneous loads from one bus value
    set_mar(4'h6);
    prog_write(4'h6, 8'h33);
    cw_step(12'h240);
    chk("multi_inst", {4'h0, inst}, 8'h03);
    chk("multi_out", out_reg, 8'h33);
    cw_step(12'h3F3); chk("multi_a", last_bus, 8'h33);
    cw_step(12'h3A3); chk("multi_ir_lo", last_bus, 8'h03);
    cw_step(12'h3E7); chk("multi_a_plus_b", last_bus, 8'h66);

    // Random control words, program writes and clears against the model
    for (int i = 0; i < 400; i++) begin
      logic [11:0] cw;
      cw = IDLE ^ 12'($urandom & $urandom & $urandom);
      step(cw, ($urandom % 6) == 0, 4'($urandom), 8'($urandom), 1'($urandom),
           ($urandom % 40) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
